spi_reg_slave: RTL and testbench



---
 rtl/reg_intf_pkg.sv | 18 +
 rtl/spi_reg_slave_if.sv | 31 +++
 rtl/spi_sync_edge.sv | 31 +++
 rtl/spi_reg_slave.sv | 214 +++++++++++++++++++++
 tb/tb_spi_reg_slave.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/reg_intf_pkg.sv
// reg_intf_pkg: shared widths and FSM state type for the SPI register slave.
// Contents: SPI_ADDR_W, SPI_DATA_W, SPI_FRAME_BITS, spi_slv_state_t.
package reg_intf_pkg;

    localparam int SPI_ADDR_W     = 14;
    localparam int SPI_DATA_W     = 16;
    localparam int SPI_FRAME_BITS = 32;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        RW,
        TURN,
        DATA,
        WAIT_SS
    } spi_slv_state_t;

endpackage

// File: rtl/spi_reg_slave_if.sv
// spi_reg_slave_if: internal register bus driven by the SPI slave.
// master: drives reg_addr/reg_wdata/reg_wr_en/reg_rd_en, takes reg_rdata.
// slave : register-file side, the mirror image.
interface spi_reg_slave_if
    import reg_intf_pkg::*;
#(
    parameter int ADDR_W = SPI_ADDR_W,
    parameter int DATA_W = SPI_DATA_W
);
    logic [ADDR_W-1:0] reg_addr;
    logic [DATA_W-1:0] reg_wdata;
    logic              reg_wr_en;
    logic              reg_rd_en;
    logic [DATA_W-1:0] reg_rdata;

    modport master (
        output reg_addr,
        output reg_wdata,
        output reg_wr_en,
        output reg_rd_en,
        input  reg_rdata
    );

    modport slave (
        input  reg_addr,
        input  reg_wdata,
        input  reg_wr_en,
        input  reg_rd_en,
        output reg_rdata
    );
endinterface

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: STAGES-deep synchronizer with rise/fall detection.
// Ports: clk, rst, din (async in), q (synced level), rise, fall (1-clk pulses).
module spi_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic q,
    output logic rise,
    output logic fall
);
    logic [STAGES-1:0] sync;
    logic              prev;

    // Reset to 0: a select that is still low after reset produces no
    // falling edge, so a half-finished frame is ignored until SS goes high.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync <= '0;
            prev <= 1'b0;
        end else begin
            sync <= {sync[STAGES-2:0], din};
            prev <= sync[STAGES-1];
        end
    end

    assign q    = sync[STAGES-1];
    assign rise = q & ~prev;
    assign fall = ~q & prev;
endmodule

// File: rtl/spi_reg_slave.sv
// spi_reg_slave: SPI slave decoding 32-bit frames into register-bus strobes.
// Ports: clk, rst (sync, high), SCLK/SS/MOSI in, MISO out, bus (register
// bus master modport), frame_err pulse, err_cnt (SPI_REG_SLAVE_ERR_CNT_EN).
module spi_reg_slave
    import reg_intf_pkg::*;
#(
    parameter int ADDR_W      = SPI_ADDR_W,
    parameter int DATA_W      = SPI_DATA_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            SCLK,
    input  logic            SS,
    input  logic            MOSI,
    output logic            MISO,
    spi_reg_slave_if.master bus,
    output logic            frame_err,
    output logic [7:0]      err_cnt
);
    localparam int             CNT_W     = $clog2(SPI_FRAME_BITS);
    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

    logic sclk_q, sclk_rise, sclk_fall;
    logic ss_q, ss_rise, ss_fall;
    logic mosi;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic sync_unused;

    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sclk (
        .clk  (clk),
        .rst  (rst),
        .din  (SCLK),
        .q    (sclk_q),
        .rise (sclk_rise),
        .fall (sclk_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_ss (
        .clk  (clk),
        .rst  (rst),
        .din  (SS),
        .q    (ss_q),
        .rise (ss_rise),
        .fall (ss_fall)
    );

    assign sync_unused = sclk_q ^ ss_rise;

    // Same depth as SCLK so the data bit lines up with the detected edge.
    always_ff @(posedge clk) begin
        if (rst) mosi_sync <= '0;
        else     mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
    end
    assign mosi = mosi_sync[SYNC_STAGES-1];

    spi_slv_state_t    state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [ADDR_W-1:0] addr_sh, addr_sh_n;
    logic [DATA_W-1:0] data_sh, data_sh_n;
    logic [DATA_W-1:0] tx_sh, tx_n;
    logic [ADDR_W-1:0] addr_q, addr_n;
    logic [DATA_W-1:0] wdata_q, wdata_n;
    logic              rw, rw_n;
    logic              miso_q, miso_n;
    logic              wr_q, wr_n;
    logic              rd_q, rd_n;
    logic              rd_d1;
    logic              err_q, err_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            addr_sh <= '0;
            data_sh <= '0;
            tx_sh   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rw      <= 1'b0;
            miso_q  <= 1'b0;
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            rd_d1   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            addr_sh <= addr_sh_n;
            data_sh <= data_sh_n;
            tx_sh   <= tx_n;
            addr_q  <= addr_n;
            wdata_q <= wdata_n;
            rw      <= rw_n;
            miso_q  <= miso_n;
            wr_q    <= wr_n;
            rd_q    <= rd_n;
            rd_d1   <= rd_q;
            err_q   <= err_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        addr_sh_n = addr_sh;
        data_sh_n = data_sh;
        tx_n      = tx_sh;
        addr_n    = addr_q;
        wdata_n   = wdata_q;
        rw_n      = rw;
        miso_n    = miso_q;
        wr_n      = 1'b0;
        rd_n      = 1'b0;
        err_n     = 1'b0;

        // Read data is valid the clk after the read strobe.
        if (rd_d1) tx_n = bus.reg_rdata;

        unique case (state)
            IDLE: begin
                if (ss_fall) begin
                    state_n = ADDR;
                    cnt_n   = '0;
                end
            end
            ADDR: begin
                if (sclk_rise) begin
                    addr_sh_n = {addr_sh[ADDR_W-2:0], mosi};
                    if (cnt == ADDR_LAST) begin
                        state_n = RW;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
            end
            RW: begin
                if (sclk_rise) begin
                    rw_n    = mosi;
                    state_n = TURN;
                    cnt_n   = '0;
                    if (!mosi) begin
                        addr_n = addr_sh;
                        rd_n   = 1'b1;
                    end
                end
            end
            TURN: begin
                // cnt marks that the turnaround bit's rising edge was seen;
                // the fall after it starts driving MISO.
                if (sclk_rise) begin
                    cnt_n = 1;
                end else if (sclk_fall && cnt == 1) begin
                    state_n = DATA;
                    cnt_n   = '0;
                    miso_n  = tx_n[DATA_W-1];
                    tx_n    = {tx_n[DATA_W-2:0], 1'b0};
                end
            end
            DATA: begin
                if (sclk_rise) begin
                    data_sh_n = {data_sh[DATA_W-2:0], mosi};
                    if (cnt == DATA_LAST) begin
                        state_n = WAIT_SS;
                        miso_n  = 1'b0;
                        if (rw) begin
                            addr_n  = addr_sh;
                            wdata_n = data_sh_n;
                            wr_n    = 1'b1;
                        end
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end else if (sclk_fall && !rw) begin
                    miso_n = tx_n[DATA_W-1];
                    tx_n   = {tx_n[DATA_W-2:0], 1'b0};
                end
            end
            WAIT_SS: begin
            end
            default: state_n = IDLE;
        endcase

        // SS high is applied after any edge in the same clk, so a frame
        // completed on this edge lands in WAIT_SS and is not an abort.
        if (ss_q) begin
            if (state_n != IDLE && state_n != WAIT_SS) err_n = 1'b1;
            state_n = IDLE;
            cnt_n   = '0;
            miso_n  = 1'b0;
        end
    end

    assign MISO          = (state == DATA) && !rw && miso_q;
    assign bus.reg_addr  = addr_q;
    assign bus.reg_wdata = wdata_q;
    assign bus.reg_wr_en = wr_q;
    assign bus.reg_rd_en = rd_q;
    assign frame_err     = err_q;

`ifdef SPI_REG_SLAVE_ERR_CNT_EN
    logic [7:0] err_total;

    always_ff @(posedge clk) begin
        if (rst)                             err_total <= '0;
        else if (err_q && err_total != 8'hFF) err_total <= err_total + 8'd1;
    end
    assign err_cnt = err_total;
`else
    assign err_cnt = 8'h00;
`endif
endmodule

// File: tb/tb_spi_reg_slave.sv
// tb_spi_reg_slave: randomized frame-level bench with scoreboard for
// spi_reg_slave; expected bus strobes are queued and checked by a monitor.
module tb_spi_reg_slave;
    logic       clk = 1'b0;
    logic       rst;
    logic       sclk, ss, mosi;
    logic       miso;
    logic       frame_err;
    logic [7:0] err_cnt;

    spi_reg_slave_if bus ();

    spi_reg_slave dut (
        .clk       (clk),
        .rst       (rst),
        .SCLK      (sclk),
        .SS        (ss),
        .MOSI      (mosi),
        .MISO      (miso),
        .bus       (bus),
        .frame_err (frame_err),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          kind;
        logic [13:0] a;
        logic [15:0] d;
    } ev_t;

    localparam int K_WR  = 1;
    localparam int K_RD  = 2;
    localparam int K_ERR = 3;

    ev_t         expq[$];
    logic [15:0] model[int];
    logic [15:0] rf[int];
    int          errs = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic wclk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] model_rd(input logic [13:0] a);
        return model.exists(int'(a)) ? model[int'(a)] : 16'h0;
    endfunction

    function automatic logic [7:0] exp_err_cnt();
`ifdef SPI_REG_SLAVE_ERR_CNT_EN
        return (errs > 255) ? 8'hFF : 8'(errs);
`else
        return 8'h00;
`endif
    endfunction

    // Register file answering the bus one clk after a read strobe.
    initial begin
        bus.reg_rdata = '0;
        forever begin
            logic [13:0] ra;
            @(posedge clk);
            if (bus.reg_wr_en) rf[int'(bus.reg_addr)] = bus.reg_wdata;
            if (bus.reg_rd_en) begin
                ra = bus.reg_addr;
                #1;
                bus.reg_rdata = rf.exists(int'(ra)) ? rf[int'(ra)] : 16'h0;
            end
        end
    end

    // Monitor: every strobe on the bus must match the next expected event.
    always @(negedge clk) begin
        if (!rst && (bus.reg_wr_en || bus.reg_rd_en || frame_err)) begin
            int  k;
            ev_t e;
            k = bus.reg_wr_en ? K_WR : (bus.reg_rd_en ? K_RD : K_ERR);
            if (expq.size() == 0) begin
                chk("unexpected_event", 32'(k), 32'(0));
            end else begin
                e = expq.pop_front();
                chk("event_kind", 32'(k), 32'(e.kind));
                if (e.kind == K_WR || e.kind == K_RD)
                    chk("reg_addr", 32'(bus.reg_addr), 32'(e.a));
                if (e.kind == K_WR)
                    chk("reg_wdata", 32'(bus.reg_wdata), 32'(e.d));
            end
        end
    end

    // One SS window of npulse SCLK periods (4 clk each). rst_at >= 0
    // pulses rst before that SCLK bit.
    task automatic frame(input logic [13:0] a, input logic w,
                         input logic [15:0] d, input int npulse,
                         input int rst_at);
        logic [31:0] fr;
        logic [15:0] rx;
        logic [15:0] exp_rx;
        bit          done;
        fr     = {a, w, 1'b0, d};
        rx     = '0;
        exp_rx = w ? 16'h0 : model_rd(a);
        done   = (npulse >= 32) && (rst_at < 0);
        if (rst_at < 0) begin
            if (npulse >= 32) begin
                expq.push_back('{w ? K_WR : K_RD, a, d});
            end else begin
                if (!w && npulse >= 15) expq.push_back('{K_RD, a, 16'h0});
                expq.push_back('{K_ERR, 14'h0, 16'h0});
                errs++;
            end
        end
        ss = 1'b0;
        wclk(4);
        for (int i = 0; i < npulse; i++) begin
            if (i == rst_at) begin
                rst = 1'b1;
                wclk(2);
                rst = 1'b0;
                wclk(1);
                errs = 0;
                chk("rst_reg_addr", 32'(bus.reg_addr), 32'h0);
                chk("rst_reg_wdata", 32'(bus.reg_wdata), 32'h0);
                chk("rst_miso", 32'(miso), 32'h0);
                chk("rst_err_cnt", 32'(err_cnt), 32'h0);
            end
            mosi = (i < 32) ? fr[31-i] : 1'($urandom);
            wclk(2);
            sclk = 1'b1;
            wclk(2);
            if (i >= 16 && i < 32) rx = {rx[14:0], miso};
            sclk = 1'b0;
        end
        wclk(2);
        ss = 1'b1;
        wclk(8);
        if (done) begin
            chk(w ? "miso_idle_on_write" : "miso_read_data",
                32'(rx), 32'(exp_rx));
            if (w) model[int'(a)] = d;
        end
        chk("err_cnt", 32'(err_cnt), 32'(exp_err_cnt()));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst  = 1'b1;
        sclk = 1'b0;
        ss   = 1'b1;
        mosi = 1'b0;
        wclk(3);
        chk("reset_miso", 32'(miso), 32'h0);
        chk("reset_reg_addr", 32'(bus.reg_addr), 32'h0);
        chk("reset_reg_wdata", 32'(bus.reg_wdata), 32'h0);
        chk("reset_wr_en", 32'(bus.reg_wr_en), 32'h0);
        chk("reset_rd_en", 32'(bus.reg_rd_en), 32'h0);
        chk("reset_frame_err", 32'(frame_err), 32'h0);
        chk("reset_err_cnt", 32'(err_cnt), 32'h0);
        rst = 1'b0;
        wclk(6);

        frame(14'h0123, 1'b1, 16'hBEEF, 32, -1);

        model[5] = 16'h1234;
        rf[5]    = 16'h1234;
        frame(14'h0005, 1'b0, 16'h0000, 32, -1);

        frame(14'h0777, 1'b1, 16'hCAFE, 10, -1);
        frame(14'h0042, 1'b1, 16'h1357, 32, -1);

        frame(14'h0AAA, 1'b1, 16'h5555, 40, -1);

        frame(14'h0033, 1'b1, 16'hDEAD, 32, 20);
        frame(14'h0034, 1'b1, 16'hF00D, 32, -1);

        frame(14'h0001, 1'b1, 16'hFFFF, 32, -1);
        frame(14'h0001, 1'b0, 16'h0000, 32, -1);

        for (int n = 0; n < 30; n++) begin
            logic [13:0] a;
            logic        w;
            int          np;
            a  = 14'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) a = a | 14'h3FF0;
            w  = 1'($urandom);
            np = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 31)
                                             : $urandom_range(32, 40);
            frame(a, w, 16'($urandom), np, -1);
        end

        wclk(4);
        chk("scoreboard_drained", 32'(expq.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule
